cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter_if.sv | 31 +++
 rtl/cacheline_adapter.sv | 112 +++++++++++
 tb/tb_cacheline_adapter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_if.sv
// Cache-control <-> memory bundle for the cacheline adapter; slave is the adapter's view.
// One interface carries both the cache-facing and memory-facing sides.
interface cacheline_adapter_if #(
  parameter int S_LINE  = 256,
  parameter int S_BURST = 64
);
  logic [S_LINE-1:0]  line_i;
  logic [S_LINE-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [S_BURST-1:0] burst_i;
  logic [S_BURST-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;
  logic [15:0]        rd_count_o;
  logic [15:0]        wr_count_o;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o, rd_count_o, wr_count_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o, rd_count_o, wr_count_o
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits cache-line writebacks into memory beats and assembles fills from beats; resp_o pulses in DONE.
// Optional feature macro CACHELINE_ADAPTER_PERF_CNT_EN enables saturating read/write transaction counters.
module cacheline_adapter #(
  parameter int S_LINE  = 256,
  parameter int S_BURST = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adapter_if.slave   bus
);
  localparam int BEATS = S_LINE / S_BURST;
  localparam int CW    = $clog2(BEATS);
  localparam int OFS   = $clog2(S_LINE / 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     beat;
  logic [S_LINE-1:0] wr_line;
  logic              op_write;
  logic              last_beat;

  assign last_beat = (beat == CW'(BEATS - 1));

  // The writeback line shifts down one beat per ack, so the low slice is always the current beat.
  assign bus.burst_o = wr_line[S_BURST-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      beat          <= '0;
      wr_line       <= '0;
      op_write      <= 1'b0;
      bus.line_o    <= '0;
      bus.address_o <= '0;
      bus.read_o    <= 1'b0;
      bus.write_o   <= 1'b0;
      bus.resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (bus.write_i) begin
            state         <= WRITE;
            op_write      <= 1'b1;
            wr_line       <= bus.line_i;
            bus.write_o   <= 1'b1;
            bus.address_o <= {bus.address_i[31:OFS], OFS'(0)};
          end else if (bus.read_i) begin
            state         <= READ;
            op_write      <= 1'b0;
            bus.read_o    <= 1'b1;
            bus.address_o <= {bus.address_i[31:OFS], OFS'(0)};
          end
        end
        READ: begin
          if (bus.resp_i) begin
            bus.line_o[int'(beat)*S_BURST +: S_BURST] <= bus.burst_i;
            beat <= beat + CW'(1);
            if (last_beat) begin
              bus.read_o <= 1'b0;
              bus.resp_o <= 1'b1;
              state      <= DONE;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            wr_line <= wr_line >> S_BURST;
            beat    <= beat + CW'(1);
            if (last_beat) begin
              bus.write_o <= 1'b0;
              bus.resp_o  <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          bus.resp_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic        unused_bits;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state == DONE) begin
      if (op_write && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
      if (!op_write && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
    end
  end

  assign bus.rd_count_o = rd_cnt;
  assign bus.wr_count_o = wr_cnt;
  assign unused_bits    = ^bus.address_i[OFS-1:0];
`else
  logic unused_bits;

  assign bus.rd_count_o = '0;
  assign bus.wr_count_o = '0;
  assign unused_bits    = ^{bus.address_i[OFS-1:0], op_write};
`endif
endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: stimulus queues expected beats/completions, a monitor checks them.
module tb_cacheline_adapter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cacheline_adapter_if #(.S_LINE(256), .S_BURST(64)) bus ();

  cacheline_adapter #(.S_LINE(256), .S_BURST(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [255:0] line;
    logic [31:0]  addr;
    int           done_cyc;
    bit           is_wr;
  } done_t;

  done_t        done_q[$];
  logic [63:0]  beat_q[$];
  logic [255:0] model_line = '0;
  int           m_rd = 0;
  int           m_wr = 0;
  bit           prev_resp = 1'b0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor samples just after the negedge, once the stimulus for the cycle is settled.
  initial begin
    done_t e;
    logic [63:0] b;
    forever begin
      @(negedge clk);
      #1;
      if (rst && bus.write_o && bus.resp_i) begin
        if (beat_q.size() == 0) chk("beat_unexpected", {255'd0, bus.write_o}, 256'd0);
        else begin
          b = beat_q.pop_front();
          chk("burst_o", {192'd0, bus.burst_o}, {192'd0, b});
        end
      end
      if (bus.resp_o) begin
        if (prev_resp) chk("resp_pulse_width", {255'd0, bus.resp_o}, 256'd0);
        if (done_q.size() == 0) chk("resp_unexpected", {255'd0, bus.resp_o}, 256'd0);
        else begin
          e = done_q.pop_front();
          chk("line_o", bus.line_o, e.line);
          chk("address_o", {224'd0, bus.address_o}, {224'd0, e.addr});
          chk("resp_cycle", 256'(cyc), 256'(e.done_cyc));
          chk("req_low_in_done", {254'd0, bus.read_o, bus.write_o}, 256'd0);
          chk("rd_count_o", {240'd0, bus.rd_count_o}, 256'(m_rd));
          chk("wr_count_o", {240'd0, bus.wr_count_o}, 256'(m_wr));
`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
          if (e.is_wr) m_wr++;
          else m_rd++;
`endif
        end
      end
      prev_resp = bus.resp_o;
    end
  end

  // pat bit i = resp_i in the i-th cycle after the issue cycle.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [255:0] data, input logic [15:0] pat, input int plen,
                     input bit both);
    done_t e;
    int    k;
    @(negedge clk);
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = wr ? data : ~data;
    e.addr        = {addr[31:5], 5'b0};
    e.done_cyc    = cyc + plen + 2;
    e.is_wr       = wr;
    if (wr) begin
      for (int i = 0; i < 4; i++) beat_q.push_back(data[64*i +: 64]);
      e.line = model_line;
    end else begin
      model_line = data;
      e.line     = data;
    end
    done_q.push_back(e);
    @(negedge clk);
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = ~addr;
    bus.line_i    = ~data;
    bus.resp_i    = 1'b0;
    if (both) begin
      #1;
      chk("both_write_o", {255'd0, bus.write_o}, 256'd1);
      chk("both_read_o", {255'd0, bus.read_o}, 256'd0);
    end
    k = 0;
    for (int i = 0; i < plen; i++) begin
      @(negedge clk);
      bus.resp_i  = pat[i];
      bus.burst_i = pat[i] ? data[64*k +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[i]) k++;
      if (both) begin
        #1;
        chk("both_read_o_burst", {255'd0, bus.read_o}, 256'd0);
      end
    end
    @(negedge clk);
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_line_o"}, bus.line_o, 256'd0);
    chk({tag, "_addr_burst"}, {160'd0, bus.address_o, bus.burst_o}, 256'd0);
    chk({tag, "_ctrl"}, {253'd0, bus.read_o, bus.write_o, bus.resp_o}, 256'd0);
    chk({tag, "_counts"}, {224'd0, bus.rd_count_o, bus.wr_count_o}, 256'd0);
  endtask

  initial begin
    logic [255:0] exp_rd;
    logic [255:0] exp_wr;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    rst           = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    txn(1, 0, 32'h0000_1234,
        {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
        16'h000F, 4, 0);
    txn(0, 1, 32'h0000_2000, {64'd4, 64'd3, 64'd2, 64'd1}, 16'h000F, 4, 0);
    txn(1, 0, 32'h0000_ABCD,
        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
        16'h0059, 7, 0);
    txn(1, 1, 32'h8000_003F, {64'd8, 64'd7, 64'd6, 64'd5}, 16'h000F, 4, 1);

    // Read aborted by reset after two acknowledged beats.
    @(negedge clk);
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0044;
    @(negedge clk);
    bus.read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'hE0E0_0000_0000_0000 + 64'(i);
    end
    @(negedge clk);
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    rst         = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_line = '0;
    m_rd = 0;
    m_wr = 0;
    #1;
    check_all_zero("abort");

    txn(1, 0, 32'h0000_0100, {64'h5A03, 64'h5A02, 64'h5A01, 64'h5A00}, 16'h000F, 4, 0);
    txn(0, 1, 32'h0000_0200, {64'h6B03, 64'h6B02, 64'h6B01, 64'h6B00}, 16'h0017, 5, 0);
    txn(0, 1, 32'h0000_0300, {64'h7C03, 64'h7C02, 64'h7C01, 64'h7C00}, 16'h000F, 4, 0);
    txn(1, 0, 32'h0000_0400, {64'h8D03, 64'h8D02, 64'h8D01, 64'h8D00}, 16'h000F, 4, 0);
    txn(1, 0, 32'h0000_0500, {64'h9E03, 64'h9E02, 64'h9E01, 64'h9E00}, 16'h0033, 6, 0);

    repeat (2) @(negedge clk);
    #1;
`ifdef CACHELINE_ADAPTER_PERF_CNT_EN
    exp_rd = 256'd3;
    exp_wr = 256'd2;
`else
    exp_rd = 256'd0;
    exp_wr = 256'd0;
`endif
    chk("final_rd_count", {240'd0, bus.rd_count_o}, exp_rd);
    chk("final_wr_count", {240'd0, bus.wr_count_o}, exp_wr);
    chk("final_line_o", bus.line_o, {64'h9E03, 64'h9E02, 64'h9E01, 64'h9E00});
    chk("pending_done", 256'(done_q.size()), 256'd0);
    chk("pending_beats", 256'(beat_q.size()), 256'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
